uart2sample: RTL

//  Receive-side counterpart of the sample-to-UART path: assembles pairs of UART RX bytes
//  (low byte first, then high byte) into 16-bit samples.

---
 rtl/uart2sample_pkg.sv | 31 +++
 rtl/uart2sample_gap_timer.sv | 46 ++++
 rtl/uart2sample.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart2sample_pkg.sv
// -----------------------------------------------------------------------------
// uart2sample_pkg
// Shared definitions for the UART receive-side byte-pair assembler.
//   state_e      : pairing FSM encodings (waiting for low / high byte)
//   BYTE_W       : width of one UART byte
//   SAMPLE_W     : width of an assembled sample
//   LOW_FIRST    : byte order on the wire, common with the transmit splitter
//   pack_sample  : places the two received bytes according to LOW_FIRST
// -----------------------------------------------------------------------------
package uart2sample_pkg;

    typedef enum logic {
        s_WAIT_LOW  = 1'b0,
        s_WAIT_HIGH = 1'b1
    } state_e;

    localparam int BYTE_W   = 8;
    localparam int SAMPLE_W = 16;

    localparam bit LOW_FIRST = 1'b1;

    // first_b is the byte received first, second_b the byte received second.
    function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [BYTE_W-1:0] first_b,
                                                         input logic [BYTE_W-1:0] second_b);
        if (LOW_FIRST) begin
            return {second_b, first_b};
        end
        return {first_b, second_b};
    endfunction

endpackage

// File: rtl/uart2sample_gap_timer.sv
// -----------------------------------------------------------------------------
// uart2sample_gap_timer
// Counts idle cycles between the low and high byte of a pair. The count
// saturates at GAP_TIMEOUT-1 (never wraps) and flags expiry there.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset
//   clr_i     : clear count to zero (priority over run)
//   run_i     : advance count by one
//   expire_o  : count has reached GAP_TIMEOUT-1
// -----------------------------------------------------------------------------
module uart2sample_gap_timer #(
    parameter int GAP_TIMEOUT = 100000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(GAP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(GAP_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/uart2sample.sv
// -----------------------------------------------------------------------------
// uart2sample
// Pairs UART RX bytes (low byte first) into 16-bit samples and presents them
// to a consumer through a one-deep valid/ready holding register. A gap timer
// drops a lone low byte if its partner does not arrive in time.
// Ports:
//   in_clk, in_rst      : clock / asynchronous active-high reset
//   in_en               : receive enable; low drops any partial pair
//   in_rx_data/valid    : byte and 1-cycle strobe from the UART receiver
//   in_ready_sample     : consumer takes out_sample this cycle
//   out_sample/valid    : held sample and its valid flag
//   out_overrun         : 1-cycle pulse, completed sample dropped (holding full)
//   out_desync          : 1-cycle pulse, gap timeout discarded the low byte
// -----------------------------------------------------------------------------
module uart2sample
    import uart2sample_pkg::*;
#(
    parameter int GAP_TIMEOUT = 100000
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                in_en,
    input  logic [BYTE_W-1:0]   in_rx_data,
    input  logic                in_rx_valid,
    input  logic                in_ready_sample,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic                out_sample_valid,
    output logic                out_overrun,
    output logic                out_desync
);

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   low_q, low_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                desync_q, desync_d;

    logic latch_low;
    logic complete;
    logic timer_run;
    logic timer_expire;

    assign timer_run = (state_q == s_WAIT_HIGH) && in_en && !in_rx_valid;

    uart2sample_gap_timer #(
        .GAP_TIMEOUT(GAP_TIMEOUT)
    ) u_gap_timer (
        .clk_i   (in_clk),
        .rst_i   (in_rst),
        .clr_i   (latch_low),
        .run_i   (timer_run),
        .expire_o(timer_expire)
    );

    // Pairing FSM. In WAIT_HIGH the enable wins, then an arriving byte, then
    // the timeout, so a byte landing on the expiry cycle still completes.
    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        latch_low = 1'b0;
        complete  = 1'b0;
        desync_d  = 1'b0;
        unique case (state_q)
            s_WAIT_LOW: begin
                if (in_en && in_rx_valid) begin
                    low_d     = in_rx_data;
                    latch_low = 1'b1;
                    state_d   = s_WAIT_HIGH;
                end
            end
            s_WAIT_HIGH: begin
                if (!in_en) begin
                    state_d = s_WAIT_LOW;
                end else if (in_rx_valid) begin
                    complete = 1'b1;
                    state_d  = s_WAIT_LOW;
                end else if (timer_expire) begin
                    desync_d = 1'b1;
                    state_d  = s_WAIT_LOW;
                end
            end
            default: state_d = s_WAIT_LOW;
        endcase
    end

    // Holding register: a new sample may replace one being consumed in the
    // same cycle; otherwise a full register keeps the old sample.
    always_comb begin
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (complete) begin
            if (!valid_q || in_ready_sample) begin
                sample_d = pack_sample(low_q, in_rx_data);
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && in_ready_sample) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q   <= s_WAIT_LOW;
            low_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            desync_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            low_q     <= low_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            desync_q  <= desync_d;
        end
    end

    assign out_sample       = sample_q;
    assign out_sample_valid = valid_q;
    assign out_overrun      = overrun_q;
    assign out_desync       = desync_q;

endmodule
